// File: rtl/leading_one.sv
`default_nettype none
// ============================================================================
// Module   : leading_one
// Function : Registered leading-one detector. Reports the index of the
//            highest set bit of check_bits one cycle later, or WIDTH when
//            check_bits is all zero.
// Revision : 1.0 - initial release
// ============================================================================

module leading_one #(
  parameter  int WIDTH = 8,
  localparam int OUT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] check_bits,
  output logic [OUT_W-1:0] ld_o
);

  localparam int               c_idx_w     = $clog2(WIDTH);
  localparam logic [OUT_W-1:0] c_none_code = OUT_W'(WIDTH);

  // Binary priority tree folded in place: at each level node k combines
  // children 2k+1 (upper) and 2k (lower). Children are read before node k
  // is overwritten, so one array serves every level.
  function automatic logic [OUT_W-1:0] f_encode(input logic [WIDTH-1:0] bits);
    logic [WIDTH-1:0]   v;
    logic [c_idx_w-1:0] idx [WIDTH];
    v = bits;
    for (int k = 0; k < WIDTH; k++) begin
      idx[k] = '0;
    end
    for (int lv = 0; lv < c_idx_w; lv++) begin
      for (int k = 0; k < (WIDTH >> (lv + 1)); k++) begin
        if (v[2*k+1]) begin
          idx[k] = idx[2*k+1] | c_idx_w'(1 << lv);
        end else begin
          idx[k] = idx[2*k];
        end
        v[k] = v[2*k+1] | v[2*k];
      end
    end
    // With no valid leaf every index stays zero, so this yields WIDTH.
    return {~v[0], idx[0]};
  endfunction

  logic [OUT_W-1:0] w_enc;
  logic [OUT_W-1:0] r_ld;

  always_comb begin
    w_enc = f_encode(check_bits);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ld <= c_none_code;
    end else begin
      r_ld <= w_enc;
    end
  end

  assign ld_o = r_ld;

endmodule

`default_nettype wire

// File: tb/tb_leading_one.sv
`default_nettype none
// ============================================================================
// Module   : tb_leading_one
// Function : Self-checking bench for leading_one at WIDTH 8 and WIDTH 16.
// Revision : 1.0 - initial release
// ============================================================================

module tb_leading_one;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  cb    = 8'hFF;
  logic [3:0]  ld;
  logic [15:0] cb16  = 16'h0000;
  logic [4:0]  ld16;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  leading_one #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .check_bits (cb),
    .ld_o       (ld)
  );

  leading_one #(.WIDTH(16)) dut16 (
    .clk        (clk),
    .rst_n      (rst_n),
    .check_bits (cb16),
    .ld_o       (ld16)
  );

  // Reference: scan from the MSB down; zero input gives w.
  function automatic int ref_lo(input logic [15:0] b, input int w);
    for (int i = w - 1; i >= 0; i--) begin
      if (b[i]) return i;
    end
    return w;
  endfunction

  logic [3:0] exp8  = 4'd8;
  logic [4:0] exp16 = 5'd16;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp8  <= 4'd8;
      exp16 <= 5'd16;
    end else begin
      exp8  <= 4'(ref_lo({8'h00, cb}, 8));
      exp16 <= 5'(ref_lo(cb16, 16));
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d at %0t", name, act, req, $time);
    end
  endtask

  // Mid-cycle compare plus a compare just before the next edge (output must hold).
  always @(negedge clk) begin
    check("model8", {12'h0, ld}, {12'h0, exp8});
    check("model16", {11'h0, ld16}, {11'h0, exp16});
    #4;
    check("hold8", {12'h0, ld}, {12'h0, exp8});
    check("hold16", {11'h0, ld16}, {11'h0, exp16});
  end

  logic       pend      = 1'b0;
  logic [3:0] pend_exp  = 4'd0;
  string      pend_name = "";

  // Drive b after the next edge; the hand value for the previous input is
  // checked at the same point, exactly one cycle after it was driven.
  task automatic push(input logic [7:0] b, input logic [3:0] req, input string nm);
    @(posedge clk);
    #2;
    if (pend) check(pend_name, {12'h0, ld}, {12'h0, pend_exp});
    cb        = b;
    pend      = 1'b1;
    pend_exp  = req;
    pend_name = nm;
  endtask

  task automatic flush();
    @(posedge clk);
    #2;
    if (pend) check(pend_name, {12'h0, ld}, {12'h0, pend_exp});
    pend = 1'b0;
  endtask

  initial begin
    // Asynchronous reset with all ones at the input.
    #1 rst_n = 1'b0;
    #1 check("rst_async", {12'h0, ld}, 16'd8);
    repeat (2) @(negedge clk);
    check("rst_hold", {12'h0, ld}, 16'd8);
    #1 rst_n = 1'b1;
    pend      = 1'b1;
    pend_exp  = 4'd7;
    pend_name = "rst_release";

    push(8'b0000_1110, 4'd3, "dir_0E");
    push(8'b0010_1101, 4'd5, "dir_2D");
    push(8'b0000_0001, 4'd0, "dir_01");
    push(8'b1000_0000, 4'd7, "dir_80");
    push(8'h00,        4'd8, "dir_00");

    for (int i = 0; i < 8; i++) push(8'(1 << i), 4'(i), "walk_one");
    for (int i = 0; i < 8; i++) push(8'((2 << i) - 1), 4'(i), "walk_fill");

    push(8'h01, 4'd0, "tp_01");
    push(8'h80, 4'd7, "tp_80");
    push(8'h00, 4'd8, "tp_00");
    push(8'h40, 4'd6, "tp_40");

    // Reset between edges while the output shows 5.
    push(8'b0010_1101, 4'd5, "pre_rst");
    flush();
    #4 rst_n = 1'b0;
    #1 check("rst_mid", {12'h0, ld}, 16'd8);
    @(negedge clk);
    check("rst_mid_hold", {12'h0, ld}, 16'd8);
    #1 rst_n = 1'b1;
    #1 check("rst_mid_release", {12'h0, ld}, 16'd8);
    push(8'b0000_1110, 4'd3, "resume_0E");
    push(8'h80,        4'd7, "resume_80");
    flush();

    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #2 cb = 8'(i);
    end

    // 16-bit instance.
    @(posedge clk);
    #2 cb16 = 16'h8000;
    @(posedge clk);
    #2 check("w16_8000", {11'h0, ld16}, 16'd15);
    cb16 = 16'h0000;
    @(posedge clk);
    #2 check("w16_0000", {11'h0, ld16}, 16'd16);
    cb16 = 16'h0103;
    @(posedge clk);
    #2 check("w16_0103", {11'h0, ld16}, 16'd8);
    for (int i = 0; i < 16; i++) begin
      cb16 = 16'(1 << i);
      @(posedge clk);
      #2;
    end
    for (int i = 0; i < 64; i++) begin
      cb16 = 16'($urandom_range(0, 65535));
      cb   = 8'($urandom_range(0, 255));
      @(posedge clk);
      #2;
    end

    repeat (2) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/leading_one.md
# leading_one

Registered leading-one (most-significant set bit) detector. Each clock it samples an input vector and reports the bit index of the highest `1`. An all-zero input returns a dedicated "none found" code. It sits in datapath normalisation and priority logic, e.g. ahead of shifters and arbiters, wherever a position index of the MSB is needed one cycle after the data.

## Interface
- WIDTH, 8, input vector width; power of two, ≥ 2.
- OUT_W, $clog2(WIDTH)+1 (= 4 for WIDTH 8), output width; derived localparam, not overridable.
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous, active-low; one clock domain only.
- check_bits  input  WIDTH  vector to scan; bit WIDTH-1 is the MSB.
- ld_o  output  OUT_W  registered result: index of the highest set bit, or the none code.

## Operation
- Result encoding:
  - If check_bits ≠ 0: ld_o = index i of the highest set bit, i in 0..WIDTH-1. The top bit ld_o[OUT_W-1] = 0.
  - If check_bits = 0: ld_o = WIDTH (4'b1000 for WIDTH 8), the none code. Only the top bit is set.
- Bits below the leading one are don't-care. Examples: 0000_1110 → 3; 0010_1101 → 5; 0000_0001 → 0; 1xxx_xxxx → 7.
- Encoder structure: a binary priority tree of log2(WIDTH) levels. Each node takes (valid, index) from its upper and lower halves. Priority goes to the upper half when it is valid; otherwise the lower half's index is used with the half-select bit cleared. The root's valid = |check_bits.
- The combinational encoder feeds a single output register. There is no other state: no FSM and no handshake.
- No X propagation from unused index bits: every output bit is driven in all cases.

## Timing
- Latency: 1 cycle. check_bits is sampled at rising edge N, and the corresponding ld_o is valid after edge N until edge N+1.
- There is no combinational path from check_bits to ld_o.
- A new input is accepted every cycle (throughput 1/cycle). A back-to-back change gives a back-to-back result.
- Reset:
  - rst_n low forces ld_o = none code (WIDTH) immediately, without waiting for a clock edge.
  - ld_o holds that value while rst_n is low, regardless of check_bits.
- Reset release: the first edge with rst_n high captures the current check_bits. The result appears after that edge.
- Reset asserted mid-stream: the pending result is discarded and ld_o goes to the none code asynchronously.
- check_bits must meet setup/hold to clk. It is not synchronised internally.

## Test plan
- Reset: drive rst_n = 0 with check_bits = 8'hFF → ld_o = 4'b1000 immediately and for the whole reset, with no clock edge needed. Release rst_n → the next edge gives ld_o = 7.
- Directed values, one per cycle:
  - 8'b0000_1110 → 3
  - 8'b0010_1101 → 5
  - 8'b0000_0001 → 0
  - 8'b1000_0000 → 7
  - 8'h00 → 4'b1000
  - each appearing exactly one cycle after its input.
- Walking one: 1<<i for i = 0..7, then all bits up to and including i set for i = 0..7 → ld_o = i one cycle later in both sweeps.
- Latency/throughput: change check_bits every cycle through 8'h01, 8'h80, 8'h00, 8'h40 → ld_o sequence 0, 7, 8, 6 lagging by exactly one cycle. Check that ld_o never changes between edges.
- Asynchronous reset mid-stream: with ld_o = 5, assert rst_n between edges → ld_o = 4'b1000 before the next edge. Deassert rst_n → normal results resume.
- Exhaustive: all 256 inputs compared against a reference model. Also exercise WIDTH = 16 (OUT_W = 5): 16'h8000 → 15, 16'h0000 → 16.
